// File: rtl/button_move_ctrl.sv
// button_move_ctrl: synchronises and debounces four raw push-buttons and turns
// each clean press into one move command for the 2048 core (valid/ready).
// Direction encoding: 00 up, 01 down, 10 left, 11 right.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat while the button is held).
module button_move_ctrl #(
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned REPEAT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       up_button,
    input  logic       down_button,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir
);

    typedef enum logic [1:0] {StIdle, StValid, StRelease} state_e;

    // Bit order matches direction code: 0 up, 1 down, 2 left, 3 right.
    logic [3:0]       w_raw;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_b;
    logic [3:0]       r_b_d;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       w_press;
    logic [1:0]       w_win_dir;
    logic [3:0]       w_dir_onehot;
    state_e           r_state;
    logic             r_valid;
    logic [1:0]       r_dir;
`ifdef BTN_REPEAT_EN
    logic [23:0]      r_rep;
`endif

    assign w_raw        = {right_button, left_button, down_button, up_button};
    assign w_press      = r_b & ~r_b_d;
    assign w_dir_onehot = 4'b0001 << r_dir;
    assign move_valid   = r_valid;
    assign move_dir     = r_dir;

    // Two-flop synchroniser, one per button.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_sync1 <= 4'b0;
            r_sync2 <= 4'b0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncers: the stable level flips only after DB_CYCLES mismatched cycles in a row.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_b   <= 4'b0;
            r_b_d <= 4'b0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_b_d <= r_b;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_b[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    r_b[i]   <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Fixed-priority pick among simultaneous presses: up > down > left > right.
    always_comb begin
        w_win_dir = 2'd3;
        if (w_press[0])      w_win_dir = 2'd0;
        else if (w_press[1]) w_win_dir = 2'd1;
        else if (w_press[2]) w_win_dir = 2'd2;
    end

    // Move FSM with registered valid/dir; one physical press yields one move.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_dir   <= 2'd0;
`ifdef BTN_REPEAT_EN
            r_rep   <= 24'd0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (|w_press) begin
                        r_dir   <= w_win_dir;
                        r_valid <= 1'b1;
                        r_state <= StValid;
                    end
                end
                StValid: begin
                    if (move_ready) begin
                        r_valid <= 1'b0;
                        r_state <= StRelease;
`ifdef BTN_REPEAT_EN
                        r_rep   <= 24'd0;
`endif
                    end
                end
                StRelease: begin
                    if (r_b == 4'b0) begin
                        r_state <= StIdle;
`ifdef BTN_REPEAT_EN
                    end else if (!(|(r_b & w_dir_onehot)) ||
                                 (|(w_press & ~w_dir_onehot))) begin
                        // Issuing button let go, or another button joined in.
                        r_rep <= 24'd0;
                    end else if (r_rep == 24'(REPEAT_CYCLES - 1)) begin
                        r_rep   <= 24'd0;
                        r_valid <= 1'b1;
                        r_state <= StValid;
                    end else begin
                        r_rep <= r_rep + 24'd1;
`endif
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
